// File: rtl/encoder_8_3_seq.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8_3_seq
// Description : Sequential 8-to-3 encoder that emits one beat per set bit of a
//               captured vector. Optional cnt port via ENCODER_8_3_SEQ_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_8_3_seq #(
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] d,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] i,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       out_zero
`ifdef ENCODER_8_3_SEQ_COUNT_EN
    ,
    output logic [3:0] cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ZERO = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] w_idx;
    logic       w_single;

    // Later matches win, so the loop direction selects highest or lowest bit
    always_comb begin
        w_idx = 3'd0;
        if (MSB_FIRST != 0) begin
            for (int b = 0; b < 8; b++) begin
                if (pending_q[b]) w_idx = 3'(b);
            end
        end else begin
            for (int b = 7; b >= 0; b--) begin
                if (pending_q[b]) w_idx = 3'(b);
            end
        end
    end

    assign w_single = (pending_q != 8'd0) && ((pending_q & (pending_q - 8'd1)) == 8'd0);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        i         = 3'd0;
        out_last  = 1'b0;
        out_zero  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = en;
                if (en && in_valid) begin
                    if (d != 8'd0) begin
                        pending_d = d;
                        state_d   = BUSY;
                    end else begin
                        state_d   = ZERO;
                    end
                end
            end
            BUSY: begin
                out_valid = en;
                i         = w_idx;
                out_last  = w_single;
                if (en && out_ready) begin
                    pending_d[w_idx] = 1'b0;
                    if (w_single) state_d = IDLE;
                end
            end
            ZERO: begin
                out_valid = en;
                out_last  = 1'b1;
                out_zero  = 1'b1;
                if (en && out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 8'd0;
        end else if (en) begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

`ifdef ENCODER_8_3_SEQ_COUNT_EN
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && en && in_valid) begin
            cnt_d = 4'd0;
            for (int b = 0; b < 8; b++) begin
                cnt_d = cnt_d + {3'd0, d[b]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/encoder_8_3_seq.md
ENCODER_8_3_SEQ -- requirements
Module: encoder_8_3_seq

Interface
REQ-001 Parameter: MSB_FIRST, default 1, scan order for set bits (1 = bit 7 first, 0 = bit 0 first).
REQ-002 clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  block enable; low stalls all state and handshakes.
REQ-005 d  input  8  request vector to be encoded.
REQ-006 in_valid  input  1  d is valid this cycle.
REQ-007 in_ready  output  1  block accepts d this cycle.
REQ-008 i  output  3  encoded index of the current set bit.
REQ-009 out_valid  output  1  i, out_last, out_zero are valid this cycle.
REQ-010 out_ready  input  1  downstream accepts the current beat.
REQ-011 out_last  output  1  current beat is the last for the captured vector.
REQ-012 out_zero  output  1  captured vector was all zeros.
REQ-013 cnt  output  4  population count of captured vector (present only with COUNT_EN, REQ-030).

Function
REQ-014 States SHALL be IDLE, BUSY and ZERO; 8-bit pending register holds unserviced bits.
REQ-015 IDLE: in_ready = en; out_valid = 0.
REQ-016 Accept = in_valid & in_ready at a rising edge; d != 0 -> pending <= d, go BUSY; d == 0 -> go ZERO.
REQ-017 Latency SHALL be 1 cycle: out_valid asserts in the cycle after the accepting edge.
REQ-018 BUSY: out_valid = en; i = index of highest (MSB_FIRST=1) or lowest (MSB_FIRST=0) set bit of pending; out_last = 1 iff pending has exactly one set bit; out_zero = 0.
REQ-019 BUSY beat handshake = out_valid & out_ready; on it, the indexed bit SHALL clear in pending; if out_last, go IDLE.
REQ-020 Without a handshake, i, out_last and pending SHALL hold unchanged.
REQ-021 ZERO: out_valid = en, i = 0, out_last = 1, out_zero = 1; on handshake go IDLE.
REQ-022 in_ready SHALL be 0 in BUSY and ZERO; new vector accepted no earlier than the cycle after the last beat's handshake (one-cycle bubble).
REQ-023 A vector with k set bits (k = 1..8) SHALL produce exactly k beats, each index once, in scan order; d == 0 produces exactly one beat.
REQ-024 en = 0: in_ready = 0, out_valid = 0, state/pending/cnt held; resumes unchanged when en returns to 1.
REQ-025 out_ready asserted while out_valid = 0 SHALL have no effect; in_valid while in_ready = 0 SHALL be ignored (d not sampled).
REQ-026 Outputs SHALL be combinational from registered state only (no input-to-output path except via en gating of out_valid/in_ready).

Reset
REQ-027 rst_n low at a rising edge SHALL force state IDLE, pending = 0, cnt = 0, regardless of in-flight handshakes.
REQ-028 Outputs during/after reset: out_valid = 0, i = 0, out_last = 0, out_zero = 0, in_ready = en.
REQ-029 Reset mid-BUSY SHALL discard remaining beats; no beat of the old vector appears after reset.

Configuration
REQ-030 Macro ENCODER_8_3_SEQ_COUNT_EN defined: cnt port present, loaded with popcount(d) at accept (0 for d == 0), held until next accept or reset.
REQ-031 Macro undefined: cnt port and its register absent; all other behaviour identical.

Verification
REQ-032 Reset, then d = 8'b1010_0100, in_valid 1 cycle, out_ready = 1 -> beats i = 7,5,2 on 3 consecutive cycles, out_last only on i = 2, in_ready high the cycle after.
REQ-033 MSB_FIRST = 0, d = 8'hFF, out_ready = 1 -> i = 0..7 in order, out_last on i = 7, cnt = 8 (COUNT_EN).
REQ-034 d = 8'h00 -> single beat i = 0, out_zero = 1, out_last = 1, cnt = 0.
REQ-035 d = 8'h81, out_ready low 3 cycles then high -> i = 7 held 3 cycles, then i = 7, i = 0; en low 2 cycles mid-stream -> out_valid 0, sequence resumes with no loss/duplication.
REQ-036 d = 8'hF0 accepted, rst_n low after first beat -> next cycle out_valid 0, pending 0; new d = 8'h01 -> single beat i = 0.
